// File: rtl/gshare_pattern_table.sv
// gshare_pattern_table: gshare PHT of 2-bit saturating counters indexed by PC[IDX_W+1:2] ^ history.
// Define GSHARE_PHT_BYPASS_EN to forward a same-cycle update to the prediction outputs.
module gshare_pattern_table #(
  parameter int         IDX_W    = 4,
  parameter logic [1:0] CTR_INIT = 2'b01
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      IF_PC,
  input  logic [IDX_W-1:0] branch_history,
  output logic             pred_taken,
  output logic [IDX_W-1:0] pred_index,
  input  logic             ID_EX_Branch,
  input  logic             Pcsrc,
  input  logic [IDX_W-1:0] ID_EX_pht_index,
  output logic [1:0]       pht_ctr_dbg
);
  localparam int DEPTH = 2 ** IDX_W;
  logic [1:0] pht_q [DEPTH];
  logic [1:0] pht_d [DEPTH];
  logic [1:0] upd_ctr, upd_nxt, rd_ctr;
  assign pred_index = IF_PC[IDX_W+1:2] ^ branch_history;
  assign upd_ctr    = pht_q[ID_EX_pht_index];
  assign upd_nxt    = Pcsrc ? ((upd_ctr == 2'b11) ? 2'b11 : upd_ctr + 2'b01)
                            : ((upd_ctr == 2'b00) ? 2'b00 : upd_ctr - 2'b01);
  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      pht_d[i] = (ID_EX_Branch && ID_EX_pht_index == IDX_W'(i)) ? upd_nxt : pht_q[i];
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++)
      pht_q[i] <= reset ? CTR_INIT : pht_d[i];
  end
`ifdef GSHARE_PHT_BYPASS_EN
  assign rd_ctr = (!reset && ID_EX_Branch && ID_EX_pht_index == pred_index) ? upd_nxt : pht_q[pred_index];
`else
  assign rd_ctr = pht_q[pred_index];
`endif
  assign pred_taken  = rd_ctr[1];
  assign pht_ctr_dbg = rd_ctr;
endmodule

// File: tb/tb_gshare_pattern_table.sv
// tb_gshare_pattern_table: directed vectors checked every cycle against a behavioural PHT model,
// plus literal expectations from hand-worked scenarios.
module tb_gshare_pattern_table;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] IF_PC = '0;
  logic [3:0]  branch_history = '0;
  logic        pred_taken;
  logic [3:0]  pred_index;
  logic        ID_EX_Branch = 1'b0;
  logic        Pcsrc = 1'b0;
  logic [3:0]  ID_EX_pht_index = '0;
  logic [1:0]  pht_ctr_dbg;

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;
  int m [16];

  gshare_pattern_table dut (
    .clk(clk), .reset(reset), .IF_PC(IF_PC), .branch_history(branch_history),
    .pred_taken(pred_taken), .pred_index(pred_index), .ID_EX_Branch(ID_EX_Branch),
    .Pcsrc(Pcsrc), .ID_EX_pht_index(ID_EX_pht_index), .pht_ctr_dbg(pht_ctr_dbg)
  );

  always #5 clk = ~clk;

  function automatic int sat(input int c, input bit up);
    return up ? ((c >= 3) ? 3 : c + 1) : ((c <= 0) ? 0 : c - 1);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  always @(posedge clk) begin
    if (reset) for (int i = 0; i < 16; i++) m[i] <= 1;
    else if (ID_EX_Branch) m[ID_EX_pht_index] <= sat(m[ID_EX_pht_index], Pcsrc);
  end

  always @(negedge clk) begin
    int ei, ec;
    if (chk_en) begin
      ei = ((int'(IF_PC) >>> 2) & 15) ^ int'(branch_history);
      ec = m[ei];
`ifdef GSHARE_PHT_BYPASS_EN
      if (!reset && ID_EX_Branch && int'(ID_EX_pht_index) == ei) ec = sat(m[ei], Pcsrc);
`endif
      check("model_index", int'(pred_index), ei);
      check("model_ctr", int'(pht_ctr_dbg), ec);
      check("model_taken", int'(pred_taken), (ec >= 2) ? 1 : 0);
    end
  end

  task automatic cyc(input logic rst, input logic [31:0] pc, input logic [3:0] h,
                     input logic br, input logic ps, input logic [3:0] ix);
    @(posedge clk);
    #1;
    reset = rst; IF_PC = pc; branch_history = h;
    ID_EX_Branch = br; Pcsrc = ps; ID_EX_pht_index = ix;
  endtask

  task automatic lit(input string name, input int ctr);
    @(negedge clk);
    check({name, "_ctr"}, int'(pht_ctr_dbg), ctr);
    check({name, "_taken"}, int'(pred_taken), ctr >> 1);
  endtask

  initial begin
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cyc(0, 32'(i * 4), 0, 0, 0, 0);
      lit("reset_sweep", 1);
    end
    cyc(0, 32'h0000_0014, 4'b0011, 0, 0, 0);
    @(negedge clk) check("xor_idx_a", int'(pred_index), 6);
    cyc(0, 32'hFFFF_FFD7, 4'b0011, 0, 0, 0);
    @(negedge clk) check("xor_idx_b", int'(pred_index), 6);
    cyc(0, 32'h10, 0, 1, 1, 4'd5);
    cyc(0, 32'h14, 0, 0, 0, 0);
    lit("inc1", 2);
    cyc(0, 32'h10, 0, 1, 1, 4'd5);
    cyc(0, 32'h10, 0, 1, 1, 4'd5);
    lit("neighbor4", 1);
    cyc(0, 32'h14, 0, 0, 0, 0);
    lit("inc3", 3);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 32'h10, 0, 1, 0, 4'd5);
      cyc(0, 32'h14, 0, 0, 0, 0);
      lit("dec", (k < 3) ? 2 - k : 0);
    end
    cyc(0, 32'h14, 0, 0, 1, 4'd5);
    cyc(0, 32'h14, 0, 0, 0, 0);
    lit("no_branch_hold", 0);
    cyc(0, 32'h18, 0, 1, 1, 4'd6);
`ifdef GSHARE_PHT_BYPASS_EN
    lit("collide_same", 2);
`else
    lit("collide_same", 1);
`endif
    cyc(0, 32'h18, 0, 0, 0, 0);
    lit("collide_next", 2);
    cyc(0, 32'h0, 0, 1, 1, 4'd15);
    cyc(0, 32'h0, 0, 1, 1, 4'd15);
    cyc(0, 32'h3C, 0, 0, 0, 0);
    lit("train15", 3);
    cyc(1, 32'h3C, 0, 1, 1, 4'd15);
    lit("reset_cycle", 3);
    cyc(0, 32'h3C, 0, 0, 0, 0);
    lit("reset_prio", 1);
    cyc(0, 32'h14, 0, 0, 0, 0);
    lit("reset_clears5", 1);
    cyc(0, 32'h14, 0, 0, 0, 0);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/gshare_pattern_table.md
Name: gshare_pattern_table

Overview:
- Consumes the 4-bit global branch history and the fetch PC; produces a taken/not-taken prediction for the instruction in IF.
- Holds a pattern history table (PHT) of 2-bit saturating counters, indexed by PC[5:2] XOR history (gshare).
- Counters are trained when a branch resolves in ID/EX, using the same ID_EX_Branch/Pcsrc strobes that advance the history register.
- Sits in IF beside the PC mux. The index is exported so the pipeline can carry it to EX for the update.

Parameters:
- IDX_W, 4, PHT index width. Equals the history width. Table depth = 2**IDX_W.
- CTR_INIT, 2'b01, counter value loaded on reset (weakly not-taken).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- IF_PC  input  32  fetch-stage PC
- branch_history  input  IDX_W  current global history, LSB = newest outcome
- pred_taken  output  1  prediction for IF_PC, combinational
- pred_index  output  IDX_W  PHT index used for pred_taken, combinational; pipeline carries it to EX
- ID_EX_Branch  input  1  resolving instruction in EX is a conditional branch
- Pcsrc  input  1  resolved outcome, 1 = taken; qualified by ID_EX_Branch
- ID_EX_pht_index  input  IDX_W  index captured at fetch for the resolving branch
- pht_ctr_dbg  output  2  counter value at pred_index, for verification

Behaviour:
- Index computation:
  - pred_index = IF_PC[IDX_W+1:2] ^ branch_history.
  - IF_PC[1:0] and IF_PC[31:IDX_W+2] are ignored.
- Prediction: pred_taken = PHT[pred_index][1], purely combinational, zero latency.
- Counter encoding:
  - 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
- Update, on posedge clk when !reset && ID_EX_Branch:
  - Pcsrc=1: PHT[ID_EX_pht_index] <= min(ctr+1, 3).
  - Pcsrc=0: PHT[ID_EX_pht_index] <= max(ctr-1, 0).
  - No wrap: 11 stays 11 on taken; 00 stays 00 on not-taken.
  - ID_EX_Branch=0: no entry changes; Pcsrc is ignored.
  - Exactly one entry is written per cycle; all other entries hold.
- Reset:
  - When reset=1 at posedge, every entry <= CTR_INIT.
  - Reset has priority over a simultaneous update.
  - Reset asserted mid-training discards all learned state.
- Outputs after reset:
  - pred_taken = CTR_INIT[1] = 0.
  - pht_ctr_dbg = CTR_INIT.
  - pred_index follows its inputs combinationally.
- Read/write same cycle, same index (ID_EX_pht_index == pred_index while updating):
  - pred_taken reflects the old (pre-edge) value unless the optional feature is enabled.
  - The new value is visible the cycle after the edge.
- Index aliasing is intentional: distinct PC/history pairs mapping to the same index share one counter.
- Implementation: register array with per-entry next-state logic, or an equivalent flop vector. No RAM macro, no multi-cycle init.

Optional Feature:
- Macro: GSHARE_PHT_BYPASS_EN.
- Defined: when ID_EX_Branch=1 and ID_EX_pht_index == pred_index in the same cycle:
  - pred_taken and pht_ctr_dbg are driven from the saturated next-state value, not the stored one (write-to-read forwarding).
  - Reset still overrides: while reset=1, no bypass, outputs show stored values.
- Undefined: no forwarding; stored value only, as described above.

Test Plan:
- Reset, then sweep IF_PC=0x00..0x3C with branch_history=0000:
  - pred_taken=0 and pht_ctr_dbg=01 for all 16 indices.
- Index XOR check:
  - IF_PC=0x0000_0014, branch_history=0011 -> pred_index=0110.
  - IF_PC=0xFFFF_FFD7, same history -> pred_index=0110 (upper and lower PC bits ignored).
- Saturating increment:
  - Three cycles of ID_EX_Branch=1, Pcsrc=1, ID_EX_pht_index=0101 -> counter 01→10→11→11.
  - pred_taken at index 0101 becomes 1 after the first update.
  - Index 0100 remains 01.
- Saturating decrement:
  - From 11, four not-taken updates -> 10, 01, 00, 00.
  - pred_taken=0 from the second update onward.
  - ID_EX_Branch=0 with Pcsrc=1 leaves the counter unchanged.
- Same-index collision: counter at 0110 = 01, taken update to 0110 while pred_index=0110.
  - Without macro: pred_taken=0 that cycle, 1 next cycle.
  - With GSHARE_PHT_BYPASS_EN: pred_taken=1 and pht_ctr_dbg=10 that cycle.
- Reset priority:
  - Train index 1111 to 11, then assert reset together with a taken update to 1111.
  - Next cycle: counter=01, pred_taken=0.
